sync_filter_multi: RTL and testbench

- Multi-channel successor to the single-bit multi-flop synchronizer.
- Brings WIDTH independent asynchronous level inputs into the clk domain through a STAGES-deep flop chain per bit.
- Each channel then passes a programmable debounce (glitch) filter and an edge detector.
- Sticky per-channel event flags let software or a slow FSM poll for changes; sits at chip/IP boundary for pins, straps and cross-domain status levels.

---
 rtl/sync_pkg.sv | 23 ++
 rtl/sync_filter_bit.sv | 59 +++++
 rtl/sync_filter_multi.sv | 50 +++++
 tb/tb_sync_filter_multi.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared constants and elaboration helpers for the synchronizer/filter family.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;

  // Constant ceiling log2, used to size per-channel filter counters.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic bit params_ok(input int stages, input int filter_len);
    return (stages >= SYNC_MIN_STAGES) && (filter_len >= 1);
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: flop-chain synchronizer, debounce counter, filtered level and
// edge pulses registered together with the level.
module sync_filter_bit
  import sync_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILTER_LEN = 4,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] chain;
  logic          sync_bit;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], async_i};
    end
  end

  assign sync_bit = chain[STAGES-1];

  // The counter only advances while the synchronized value disagrees with the
  // current level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt     <= '0;
      level_o <= RESET_VAL;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (sync_bit == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_o <= sync_bit;
        cnt     <= '0;
        rise_o  <= sync_bit;
        fall_o  <= ~sync_bit;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sync_filter_multi.sv
// WIDTH independent synchronize/debounce/edge channels plus sticky per-channel
// change flags that software clears individually.
module sync_filter_multi
  import sync_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               STAGES     = 2,
  parameter int               FILTER_LEN = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] evt_o,
  input  logic [WIDTH-1:0] evt_clr_i
);

  if (WIDTH < 1 || !params_ok(STAGES, FILTER_LEN)) begin : g_bad_params
    $error("sync_filter_multi: need WIDTH>=1, STAGES>=%0d, FILTER_LEN>=1",
           SYNC_MIN_STAGES);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_bit #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_VAL[i])
    ) u_bit (
      .clk     (clk),
      .rstn    (rstn),
      .async_i (async_i[i]),
      .level_o (level_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

  // A new edge takes priority over a clear so that no change is ever lost.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      evt_o <= '0;
    end else begin
      evt_o <= (evt_o & ~evt_clr_i) | rise_o | fall_o;
    end
  end

endmodule

// File: tb/tb_sync_filter_multi.sv
// Scoreboard bench: two configurations driven in parallel and compared against
// a history-based reference model of the synchronize/debounce/event rules.
module tb_sync_filter_multi;

  typedef struct {
    logic [7:0] level;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] evt;
  } exp_t;

  logic       clk;
  logic       rstn;
  logic [7:0] async_i;
  logic [7:0] evt_clr_i;
  logic [7:0] level0, rise0, fall0, evt0;
  logic [7:0] level1, rise1, fall1, evt1;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference configuration table, one entry per DUT.
  int         cfg_stages[2] = '{2, 3};
  int         cfg_flen[2]   = '{4, 1};
  logic [7:0] cfg_rv[2]     = '{8'h00, 8'h3C};

  // Model state: raw input history (sync delay line) and synchronized history.
  logic [7:0] ahist[2][8];
  logic [7:0] shist[2][8];
  int         n_samp[2];
  logic [7:0] m_level[2], m_rise[2], m_fall[2], m_evt[2];

  sync_filter_multi #(.WIDTH(8), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .rstn(rstn), .async_i(async_i), .level_o(level0), .rise_o(rise0),
    .fall_o(fall0), .evt_o(evt0), .evt_clr_i(evt_clr_i)
  );

  sync_filter_multi #(.WIDTH(8), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(8'h3C)) dut1 (
    .clk(clk), .rstn(rstn), .async_i(async_i), .level_o(level1), .rise_o(rise1),
    .fall_o(fall1), .evt_o(evt1), .evt_clr_i(evt_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A level moves once the last FILTER_LEN synchronized samples since reset
  // all disagree with it; the synchronized value is the input STAGES clocks ago.
  task automatic modelStep(input int d, input logic r, input logic [7:0] a, input logic [7:0] c);
    logic [7:0] sync_v, nr, nf;
    bit all_diff;
    exp_t e;
    if (!r) begin
      for (int k = 0; k < 8; k++) begin
        ahist[d][k] = cfg_rv[d];
        shist[d][k] = cfg_rv[d];
      end
      n_samp[d]  = 0;
      m_level[d] = cfg_rv[d];
      m_rise[d]  = '0;
      m_fall[d]  = '0;
      m_evt[d]   = '0;
    end else begin
      m_evt[d] = (m_evt[d] & ~c) | m_rise[d] | m_fall[d];
      sync_v = ahist[d][cfg_stages[d]-1];
      for (int k = 7; k > 0; k--) shist[d][k] = shist[d][k-1];
      shist[d][0] = sync_v;
      n_samp[d] = n_samp[d] + 1;
      nr = '0;
      nf = '0;
      for (int b = 0; b < 8; b++) begin
        if (n_samp[d] >= cfg_flen[d]) begin
          all_diff = 1'b1;
          for (int k = 0; k < cfg_flen[d]; k++)
            if (shist[d][k][b] == m_level[d][b]) all_diff = 1'b0;
          if (all_diff) begin
            if (m_level[d][b]) nf[b] = 1'b1;
            else nr[b] = 1'b1;
            m_level[d][b] = ~m_level[d][b];
          end
        end
      end
      m_rise[d] = nr;
      m_fall[d] = nf;
      for (int k = 7; k > 0; k--) ahist[d][k] = ahist[d][k-1];
      ahist[d][0] = a;
    end
    e.level = m_level[d];
    e.rise  = m_rise[d];
    e.fall  = m_fall[d];
    e.evt   = m_evt[d];
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    rstn      = r;
    async_i   = a;
    evt_clr_i = c;
    modelStep(0, r, a, c);
    modelStep(1, r, a, c);
  endtask

  task automatic checkField(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, cycle, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e, input logic [7:0] lv,
                             input logic [7:0] ri, input logic [7:0] fa, input logic [7:0] ev);
    checkField({tag, " level_o"}, lv, e.level);
    checkField({tag, " rise_o"}, ri, e.rise);
    checkField({tag, " fall_o"}, fa, e.fall);
    checkField({tag, " evt_o"}, ev, e.evt);
    checkField({tag, " rise&fall"}, ri & fa, 8'h00);
  endtask

  // Monitor: every clock the DUT presents a fresh output word to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkOutput("dut0", e, level0, rise0, fall0, evt0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkOutput("dut1", e, level1, rise1, fall1, evt1);
      end
    end
  end

  initial begin
    logic [7:0] cur;
    logic [7:0] clr;
    logic       r;
    rstn      = 1'b0;
    async_i   = 8'hA5;
    evt_clr_i = 8'h00;

    // Reset with inputs away from the reset value, then release.
    applyStimulus(1'b0, 8'hA5, 8'h00);
    applyStimulus(1'b0, 8'hA5, 8'h00);
    repeat (12) applyStimulus(1'b1, 8'hA5, 8'h00);

    // Return to zero, then a 3-cycle glitch and a 4-cycle pulse on bit 0.
    cur = 8'h00;
    repeat (10) applyStimulus(1'b1, cur, 8'hFF);
    repeat (3) applyStimulus(1'b1, 8'h01, 8'h00);
    repeat (10) applyStimulus(1'b1, 8'h00, 8'h00);
    repeat (4) applyStimulus(1'b1, 8'h01, 8'h00);
    repeat (10) applyStimulus(1'b1, 8'h00, 8'h00);

    // Bounce on bit 3.
    applyStimulus(1'b1, 8'h08, 8'h00);
    applyStimulus(1'b1, 8'h00, 8'h00);
    repeat (14) applyStimulus(1'b1, 8'h08, 8'h00);

    // Fall on bit 1 followed by an explicit clear.
    cur = 8'h0A;
    repeat (10) applyStimulus(1'b1, cur, 8'h00);
    cur = 8'h08;
    repeat (10) applyStimulus(1'b1, cur, 8'h00);
    applyStimulus(1'b1, cur, 8'h02);
    repeat (3) applyStimulus(1'b1, cur, 8'h00);

    // Clear bit 2 exactly while its rise pulse is visible.
    cur = 8'h0C;
    repeat (12) begin
      clr = m_rise[0] & 8'h04;
      applyStimulus(1'b1, cur, clr);
    end
    repeat (3) applyStimulus(1'b1, cur, 8'h00);

    // Reset while bit 4 is part-way through its filter window.
    cur = 8'h1C;
    repeat (4) applyStimulus(1'b1, cur, 8'hFF);
    applyStimulus(1'b0, cur, 8'h00);
    repeat (12) applyStimulus(1'b1, cur, 8'h00);

    // Random slowly-toggling inputs with sparse clears and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      clr = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 7) == 0) clr = clr | m_rise[0] | m_fall[0];
      r = ($urandom_range(0, 199) != 0);
      applyStimulus(r, cur, clr);
    end

    repeat (3) @(negedge clk);
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_errors++;
      $display("[TB] FAIL drain: got %0d/%0d pending expected 0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
